// File: rtl/ex_alu_unit_if.sv
// EX-stage ALU bus: operands, decode inputs and branch-adder inputs in; combinational and EX/MEM
// registered results out. The o_ovf/o_ovf_q pair exists only when ALU_OVF_EN is defined.
interface ex_alu_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 30
);
   logic                  i_en;
   logic [1:0]            i_alu_op;
   logic [5:0]            i_func;
   logic [DATA_WIDTH-1:0] i_opA;
   logic [DATA_WIDTH-1:0] i_opB;
   logic [4:0]            i_shift;
   logic [PC_WIDTH-1:0]   i_npc;
   logic [PC_WIDTH-1:0]   i_offset;
   logic [3:0]            o_alu_ctrl;
   logic [DATA_WIDTH-1:0] o_result;
   logic                  o_zf;
   logic [PC_WIDTH-1:0]   o_bta;
   logic [DATA_WIDTH-1:0] o_result_q;
   logic                  o_zf_q;
   logic [PC_WIDTH-1:0]   o_bta_q;
`ifdef ALU_OVF_EN
   logic                  o_ovf;
   logic                  o_ovf_q;
`endif

   modport master (
`ifdef ALU_OVF_EN
      input  o_ovf, o_ovf_q,
`endif
      output i_en, i_alu_op, i_func, i_opA, i_opB, i_shift, i_npc, i_offset,
      input  o_alu_ctrl, o_result, o_zf, o_bta, o_result_q, o_zf_q, o_bta_q
   );

   modport slave (
`ifdef ALU_OVF_EN
      output o_ovf, o_ovf_q,
`endif
      input  i_en, i_alu_op, i_func, i_opA, i_opB, i_shift, i_npc, i_offset,
      output o_alu_ctrl, o_result, o_zf, o_bta, o_result_q, o_zf_q, o_bta_q
   );
endinterface

// File: rtl/ex_alu_unit.sv
// EX-stage ALU of the 5-stage MIPS pipeline: control decode, ALU, zero flag, branch-target adder and
// EX/MEM output registers. Defining ALU_OVF_EN adds the signed-overflow flag o_ovf/o_ovf_q.
module ex_alu_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 30
) (
   input logic          i_clk,
   input logic          i_rst,
   ex_alu_unit_if.slave bus
);
   localparam int MSB = DATA_WIDTH - 1;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_SLL = 4'b1000,
      ALU_SRL = 4'b1001,
      ALU_SRA = 4'b1010,
      ALU_NOR = 4'b1100
   } alu_ctrl_e;

   alu_ctrl_e             ctrl;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] diff;
   logic [DATA_WIDTH-1:0] result;
   logic                  zf;
   logic [PC_WIDTH-1:0]   bta;

   // NOTE: every always_comb output gets a default before any branch, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin : decode
      ctrl = ALU_ADD;
      case (bus.i_alu_op)
         2'b00: ctrl = ALU_ADD;
         2'b01: ctrl = ALU_SUB;
         2'b11: ctrl = ALU_OR;
         2'b10: begin
            case (bus.i_func)
               6'b100000: ctrl = ALU_ADD;
               6'b100010: ctrl = ALU_SUB;
               6'b100100: ctrl = ALU_AND;
               6'b100101: ctrl = ALU_OR;
               6'b100110: ctrl = ALU_XOR;
               6'b100111: ctrl = ALU_NOR;
               6'b101010: ctrl = ALU_SLT;
               6'b000000: ctrl = ALU_SLL;
               6'b000010: ctrl = ALU_SRL;
               6'b000011: ctrl = ALU_SRA;
               default:   ctrl = ALU_ADD;
            endcase
         end
         default: ctrl = ALU_ADD;
      endcase
   end

   assign op_a = bus.i_opA;
   assign op_b = bus.i_opB;
   assign sum  = op_a + op_b;
   assign diff = op_a - op_b;

   always_comb begin : alu
      result = '0;
      case (ctrl)
         ALU_AND: result = op_a & op_b;
         ALU_OR:  result = op_a | op_b;
         ALU_XOR: result = op_a ^ op_b;
         ALU_NOR: result = ~(op_a | op_b);
         ALU_ADD: result = sum;
         ALU_SUB: result = diff;
         ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_SLL: result = op_b << bus.i_shift;
         ALU_SRL: result = op_b >> bus.i_shift;
         ALU_SRA: result = $unsigned($signed(op_b) >>> bus.i_shift);
         default: result = '0;
      endcase
   end

   assign zf  = ~|result;
   assign bta = bus.i_npc + bus.i_offset;

`ifdef ALU_OVF_EN
   logic ovf;
   logic ovf_d;
   logic ovf_q;

   // Overflow when same-sign inputs (ADD) or opposite-sign inputs (SUB) flip the sign of the result.
   always_comb begin : overflow
      ovf = 1'b0;
      if (ctrl == ALU_ADD) begin
         ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end else if (ctrl == ALU_SUB) begin
         ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
   end
`endif

   logic [DATA_WIDTH-1:0] result_d;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  zf_d;
   logic                  zf_q;
   logic [PC_WIDTH-1:0]   bta_d;
   logic [PC_WIDTH-1:0]   bta_q;

   always_comb begin : next_state
      result_d = result_q;
      zf_d     = zf_q;
      bta_d    = bta_q;
`ifdef ALU_OVF_EN
      ovf_d    = ovf_q;
`endif
      if (bus.i_en) begin
         result_d = result;
         zf_d     = zf;
         bta_d    = bta;
`ifdef ALU_OVF_EN
         ovf_d    = ovf;
`endif
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin : ex_mem_regs
      if (i_rst) begin
         result_q <= '0;
         zf_q     <= 1'b0;
         bta_q    <= '0;
`ifdef ALU_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         result_q <= result_d;
         zf_q     <= zf_d;
         bta_q    <= bta_d;
`ifdef ALU_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign bus.o_alu_ctrl = ctrl;
   assign bus.o_result   = result;
   assign bus.o_zf       = zf;
   assign bus.o_bta      = bta;
   assign bus.o_result_q = result_q;
   assign bus.o_zf_q     = zf_q;
   assign bus.o_bta_q    = bta_q;
`ifdef ALU_OVF_EN
   assign bus.o_ovf      = ovf;
   assign bus.o_ovf_q    = ovf_q;
`endif
endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed literal cases plus randomized stimulus compared every
// cycle against a behavioural model. Overflow checks are compiled in when ALU_OVF_EN is defined.
module tb_ex_alu_unit;
   localparam int DW = 32;
   localparam int PW = 30;

   typedef struct {
      logic [3:0]    ctrl;
      logic [DW-1:0] result;
      logic          zf;
      logic [PW-1:0] bta;
      logic          ovf;
   } model_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   cmp_en   = 0;
   bit   q_valid  = 0;

   logic [DW-1:0] eq_result;
   logic          eq_zf;
   logic [PW-1:0] eq_bta;
   logic          eq_ovf;

   ex_alu_unit_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) bus ();

   ex_alu_unit #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: decode by table, arithmetic in 64-bit signed integers, truncate at the end.
   function automatic model_t model(input logic [1:0] op, input logic [5:0] f,
                                    input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [4:0] sh, input logic [PW-1:0] npc,
                                    input logic [PW-1:0] off);
      model_t m;
      longint sa;
      longint sb;
      longint wide;
      sa = $signed(a);
      sb = $signed(b);
      if (op == 2'b00)      m.ctrl = 4'h2;
      else if (op == 2'b01) m.ctrl = 4'h6;
      else if (op == 2'b11) m.ctrl = 4'h1;
      else begin
         case (f)
            6'h20:   m.ctrl = 4'h2;
            6'h22:   m.ctrl = 4'h6;
            6'h24:   m.ctrl = 4'h0;
            6'h25:   m.ctrl = 4'h1;
            6'h26:   m.ctrl = 4'h3;
            6'h27:   m.ctrl = 4'hC;
            6'h2A:   m.ctrl = 4'h7;
            6'h00:   m.ctrl = 4'h8;
            6'h02:   m.ctrl = 4'h9;
            6'h03:   m.ctrl = 4'hA;
            default: m.ctrl = 4'h2;
         endcase
      end
      m.ovf    = 1'b0;
      m.result = '0;
      case (m.ctrl)
         4'h2: begin
            wide     = sa + sb;
            m.result = wide[DW-1:0];
            m.ovf    = (wide != longint'($signed(m.result)));
         end
         4'h6: begin
            wide     = sa - sb;
            m.result = wide[DW-1:0];
            m.ovf    = (wide != longint'($signed(m.result)));
         end
         4'h0: m.result = a & b;
         4'h1: m.result = a | b;
         4'h3: m.result = a ^ b;
         4'hC: m.result = ~(a | b);
         4'h7: m.result = (sa < sb) ? 32'd1 : 32'd0;
         4'h8: m.result = b << sh;
         4'h9: m.result = b >> sh;
         4'hA: begin
            wide     = sb >>> sh;
            m.result = wide[DW-1:0];
         end
         default: m.result = '0;
      endcase
      m.zf  = (m.result == '0);
      m.bta = npc + off;
      return m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic model_t model_now();
      return model(bus.i_alu_op, bus.i_func, bus.i_opA, bus.i_opB, bus.i_shift,
                   bus.i_npc, bus.i_offset);
   endfunction

   // Advance the register model at the edge using the inputs that were stable before it.
   task automatic tick();
      model_t m;
      @(posedge clk);
      m = model_now();
      if (rst) begin
         eq_result = '0;
         eq_zf     = 1'b0;
         eq_bta    = '0;
         eq_ovf    = 1'b0;
         q_valid   = 1'b1;
      end else if (bus.i_en) begin
         eq_result = m.result;
         eq_zf     = m.zf;
         eq_bta    = m.bta;
         eq_ovf    = m.ovf;
      end
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [4:0] sh, input logic [PW-1:0] npc,
                        input logic [PW-1:0] off, input logic en, input logic r);
      bus.i_alu_op = op;
      bus.i_func   = f;
      bus.i_opA    = a;
      bus.i_opB    = b;
      bus.i_shift  = sh;
      bus.i_npc    = npc;
      bus.i_offset = off;
      bus.i_en     = en;
      rst          = r;
   endtask

   always @(negedge clk) begin
      model_t m;
      if (cmp_en) begin
         m = model_now();
         check("cmp_ctrl",   64'(bus.o_alu_ctrl), 64'(m.ctrl));
         check("cmp_result", 64'(bus.o_result),   64'(m.result));
         check("cmp_zf",     64'(bus.o_zf),       64'(m.zf));
         check("cmp_bta",    64'(bus.o_bta),      64'(m.bta));
`ifdef ALU_OVF_EN
         check("cmp_ovf",    64'(bus.o_ovf),      64'(m.ovf));
`endif
         if (q_valid) begin
            check("cmp_result_q", 64'(bus.o_result_q), 64'(eq_result));
            check("cmp_zf_q",     64'(bus.o_zf_q),     64'(eq_zf));
            check("cmp_bta_q",    64'(bus.o_bta_q),    64'(eq_bta));
`ifdef ALU_OVF_EN
            check("cmp_ovf_q",    64'(bus.o_ovf_q),    64'(eq_ovf));
`endif
         end
      end
   end

   function automatic logic [DW-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [5:0]    funcs [10];
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [5:0]    f;
      funcs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};

      // Reset state
      drive(2'b00, 6'h00, 32'h1111_1111, 32'h2222_2222, 5'd0, 30'h123, 30'h456, 1'b1, 1'b1);
      cmp_en = 1;
      tick();
      check("rst_result_q", 64'(bus.o_result_q), 64'h0);
      check("rst_zf_q",     64'(bus.o_zf_q),     64'h0);
      check("rst_bta_q",    64'(bus.o_bta_q),    64'h0);

      // R-type ADD and its registered copy
      drive(2'b10, 6'b100000, 32'd7, 32'd5, 5'd0, 30'h0, 30'h0, 1'b1, 1'b0);
      #1;
      check("add_ctrl",   64'(bus.o_alu_ctrl), 64'h2);
      check("add_result", 64'(bus.o_result),   64'd12);
      check("add_zf",     64'(bus.o_zf),       64'h0);
      tick();
      check("add_result_q", 64'(bus.o_result_q), 64'd12);

      drive(2'b01, 6'h3F, 32'h1234, 32'h1234, 5'd0, 30'h0, 30'h0, 1'b0, 1'b0);
      #1;
      check("sub_ctrl", 64'(bus.o_alu_ctrl), 64'h6);
      check("sub_zero", 64'(bus.o_result),   64'h0);
      check("sub_zf",   64'(bus.o_zf),       64'h1);
      tick();

      drive(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0, 30'h0, 30'h0, 1'b0, 1'b0);
      #1;
      check("slt_neg", 64'(bus.o_result), 64'd1);
      tick();

      drive(2'b10, 6'b000011, 32'h0, 32'h8000_0000, 5'd4, 30'h0, 30'h0, 1'b0, 1'b0);
      #1;
      check("sra", 64'(bus.o_result), 64'hF800_0000);
      bus.i_func = 6'b000010;
      #1;
      check("srl", 64'(bus.o_result), 64'h0800_0000);
      bus.i_func  = 6'b000000;
      bus.i_opB   = 32'd1;
      bus.i_shift = 5'd31;
      #1;
      check("sll", 64'(bus.o_result), 64'h8000_0000);
      tick();

      drive(2'b00, 6'h00, 32'h0, 32'h0, 5'd0, 30'h10, 30'h3FFF_FFFE, 1'b0, 1'b0);
      #1;
      check("bta_neg", 64'(bus.o_bta), 64'h0E);
      bus.i_npc    = 30'h3FFF_FFFF;
      bus.i_offset = 30'h1;
      #1;
      check("bta_wrap", 64'(bus.o_bta), 64'h0);
      tick();

      // Load, hold with en low, then reset overriding en
      drive(2'b00, 6'h00, 32'd2, 32'd3, 5'd0, 30'h0, 30'h0, 1'b1, 1'b0);
      tick();
      check("load_q", 64'(bus.o_result_q), 64'd5);
      drive(2'b00, 6'h00, 32'd100, 32'd3, 5'd0, 30'h7, 30'h9, 1'b0, 1'b0);
      tick();
      check("hold_q", 64'(bus.o_result_q), 64'd5);
      drive(2'b00, 6'h00, 32'd100, 32'd3, 5'd0, 30'h7, 30'h9, 1'b1, 1'b1);
      tick();
      check("rst_en_result_q", 64'(bus.o_result_q), 64'h0);
      check("rst_en_zf_q",     64'(bus.o_zf_q),     64'h0);
      check("rst_en_bta_q",    64'(bus.o_bta_q),    64'h0);

`ifdef ALU_OVF_EN
      drive(2'b00, 6'h00, 32'h7FFF_FFFF, 32'd1, 5'd0, 30'h0, 30'h0, 1'b1, 1'b0);
      #1;
      check("ovf_add", 64'(bus.o_ovf), 64'h1);
      tick();
      check("ovf_add_q", 64'(bus.o_ovf_q), 64'h1);
      drive(2'b01, 6'h00, 32'h8000_0000, 32'd1, 5'd0, 30'h0, 30'h0, 1'b0, 1'b0);
      #1;
      check("ovf_sub", 64'(bus.o_ovf), 64'h1);
      bus.i_alu_op = 2'b10;
      bus.i_func   = 6'b100100;
      #1;
      check("ovf_and", 64'(bus.o_ovf), 64'h0);
      tick();
`endif

      // Randomized traffic; the negedge compare process checks every cycle.
      for (int i = 0; i < 400; i++) begin
         a = pick_operand();
         b = ($urandom_range(0, 7) == 0) ? a : pick_operand();
         f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : funcs[$urandom_range(0, 9)];
         drive(2'($urandom), f, a, b, 5'($urandom), 30'($urandom), 30'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         tick();
      end

      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
